// File: rtl/timing_gen.sv
// Horizontal/vertical display timing counters with single-cycle decode strobes.
// Optional frame counter enabled by defining TIMING_FRAME_COUNT_EN.
module timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  localparam int unsigned CNT_W    = 10,
  localparam int unsigned FC_W     = 8
) (
  input  logic             clk,
  input  logic             nrst,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hBeginPulse,
  output logic             hEndPulse,
  output logic             hCountEnd,
  output logic             hVisEnd,
  output logic             vBeginPulse,
  output logic             vEndPulse,
  output logic             vCountZero,
  output logic             vVisEnd,
  output logic             vCountEnd,
  output logic             vEndActive,
  output logic             frameStart,
  output logic [FC_W-1:0]  frameCount
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_INC   = H_VISIBLE + H_FRONT - 1;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_INC_C    = CNT_W'(H_INC);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_INC + H_SYNC);
  localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

  // Counters are fixed at 10 bits; larger timings cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_badTiming
    $error("timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  // vCount advances mid-line so it already holds the next line at hCountEnd.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hCount <= '0;
      vCount <= '0;
    end else begin
      hCount <= (hCount == H_LAST) ? '0 : hCount + CNT_W'(1);
      if (hCount == H_INC_C) begin
        vCount <= (vCount == V_LAST) ? '0 : vCount + CNT_W'(1);
      end
    end
  end

  assign hBeginPulse = (hCount == H_INC_C);
  assign hEndPulse   = (hCount == H_SYNC_END);
  assign hCountEnd   = (hCount == H_LAST);
  assign hVisEnd     = (hCount == H_VIS_LAST);
  assign vBeginPulse = hCountEnd & (vCount == V_SYNC_BEG);
  assign vEndPulse   = hCountEnd & (vCount == V_SYNC_END);
  assign vCountZero  = (vCount == '0);
  assign vVisEnd     = (vCount == V_VIS_C);
  assign vCountEnd   = (vCount == V_LAST);
  assign vEndActive  = (vCount == V_VIS_LAST);

`ifdef TIMING_FRAME_COUNT_EN
  logic [FC_W-1:0] frameCnt;

  assign frameStart = hCountEnd & vCountZero;
  assign frameCount = frameCnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frameCnt <= '0;
    end else if (frameStart) begin
      frameCnt <= frameCnt + FC_W'(1);
    end
  end
`else
  assign frameStart = 1'b0;
  assign frameCount = '0;
`endif

endmodule

// File: tb/tb_timing_gen.sv
// Bench for timing_gen: a small-timing instance runs 257 frames, a VGA-default
// instance covers the first lines; both are checked every cycle against a cycle-index model.
module tb_timing_gen;

  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 2;
  localparam int SFRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);
  localparam int NFRAMES = 257;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] sH, sV, dH, dV;
  logic sHB, sHE, sHCE, sHVE, sVB, sVE, sVZ, sVVE, sVCE, sVEA, sFS;
  logic dHB, dHE, dHCE, dHVE, dVB, dVE, dVZ, dVVE, dVCE, dVEA, dFS;
  logic [7:0] sFC, dFC;

  timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) uSmall (
    .clk(clk), .nrst(nrst), .hCount(sH), .vCount(sV),
    .hBeginPulse(sHB), .hEndPulse(sHE), .hCountEnd(sHCE), .hVisEnd(sHVE),
    .vBeginPulse(sVB), .vEndPulse(sVE), .vCountZero(sVZ), .vVisEnd(sVVE),
    .vCountEnd(sVCE), .vEndActive(sVEA), .frameStart(sFS), .frameCount(sFC)
  );

  timing_gen uVga (
    .clk(clk), .nrst(nrst), .hCount(dH), .vCount(dV),
    .hBeginPulse(dHB), .hEndPulse(dHE), .hCountEnd(dHCE), .hVisEnd(dHVE),
    .vBeginPulse(dVB), .vEndPulse(dVE), .vCountZero(dVZ), .vVisEnd(dVVE),
    .vCountEnd(dVCE), .vEndActive(dVEA), .frameStart(dFS), .frameCount(dFC)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;
  int mfcS = 0, mfcD = 0;
  logic countEn = 1'b0;
  int nVB = 0, nVE = 0, nVVE = 0, nVCE = 0, nVEA = 0, nFS = 0;
  int lastVBv = -1, lastVEv = -1, sVat191 = -1;
  int posVis = -1, posBeg = -1, posEnd = -1, posCE = -1;
  int dVat655 = -1, dVat656 = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask

  // Expected outputs from the cycle index since reset release.
  // Order: hBegin,hEnd,hCountEnd,hVisEnd,vBegin,vEnd,vZero,vVisEnd,vCountEnd,vEndActive
  function automatic logic [9:0] modelDec(input int tc, input int hv, input int hf,
                                          input int hs, input int hb, input int vv,
                                          input int vf, input int vs, input int vb,
                                          output int h, output int v);
    int ht, vt, hi;
    logic hce;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    hi = hv + hf - 1;
    h = tc % ht;
    v = ((tc + ht - hi - 1) / ht) % vt;
    hce = (h == ht - 1);
    return {h == hi, h == hi + hs, hce, h == hv - 1, hce && (v == vv + vf),
            hce && (v == vv + vf + vs), v == 0, v == vv, v == vt - 1, v == vv - 1};
  endfunction

  task automatic cmpInst(input string nm, input int hv, input int hf, input int hs,
                         input int hb, input int vv, input int vf, input int vs,
                         input int vb, input logic [9:0] aH, input logic [9:0] aV,
                         input logic [9:0] aDec, input logic aFs, input logic [7:0] aFc,
                         inout int mfc);
    int eh, ev;
    logic [9:0] eDec;
    logic eFs;
    int eFc;
    eDec = modelDec(t, hv, hf, hs, hb, vv, vf, vs, vb, eh, ev);
`ifdef TIMING_FRAME_COUNT_EN
    eFs = eDec[7] & eDec[3];
    eFc = mfc % 256;
`else
    eFs = 1'b0;
    eFc = 0;
`endif
    chk({nm, ".hCount"}, 32'(aH), 32'(eh));
    chk({nm, ".vCount"}, 32'(aV), 32'(ev));
    chk({nm, ".strobes"}, 32'(aDec), 32'(eDec));
    chk({nm, ".frameStart"}, 32'(aFs), 32'(eFs));
    chk({nm, ".frameCount"}, 32'(aFc), 32'(eFc));
    if (eFs) mfc++;
  endtask

  task automatic chkReset(input string nm, input logic [9:0] aH, input logic [9:0] aV,
                          input logic [9:0] aDec, input logic aFs, input logic [7:0] aFc);
    chk({nm, ".rst.hCount"}, 32'(aH), 32'd0);
    chk({nm, ".rst.vCount"}, 32'(aV), 32'd0);
    chk({nm, ".rst.strobes"}, 32'(aDec), 32'b0000001000);
    chk({nm, ".rst.frameStart"}, 32'(aFs), 32'd0);
    chk({nm, ".rst.frameCount"}, 32'(aFc), 32'd0);
  endtask

  // Per-cycle compare plus event logging for the literal checks.
  always @(negedge clk) begin
    if (!nrst) begin
      chkReset("small", sH, sV, {sHB, sHE, sHCE, sHVE, sVB, sVE, sVZ, sVVE, sVCE, sVEA}, sFS, sFC);
      chkReset("vga", dH, dV, {dHB, dHE, dHCE, dHVE, dVB, dVE, dVZ, dVVE, dVCE, dVEA}, dFS, dFC);
      t = 1;
      mfcS = 0;
      mfcD = 0;
    end else begin
      cmpInst("small", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, sH, sV,
              {sHB, sHE, sHCE, sHVE, sVB, sVE, sVZ, sVVE, sVCE, sVEA}, sFS, sFC, mfcS);
      cmpInst("vga", 640, 16, 96, 48, 480, 10, 2, 33, dH, dV,
              {dHB, dHE, dHCE, dHVE, dVB, dVE, dVZ, dVVE, dVCE, dVEA}, dFS, dFC, mfcD);
      if (countEn) begin
        if (sVB) begin nVB++; lastVBv = int'(sV); end
        if (sVE) begin nVE++; lastVEv = int'(sV); end
        if (sHCE && sVVE) nVVE++;
        if (sHCE && sVCE) nVCE++;
        if (sHCE && sVEA) nVEA++;
        if (sFS) nFS++;
        if (t == SFRAME - 1) sVat191 = int'(sV);
        if (t < 800) begin
          if (dHVE && posVis < 0) posVis = int'(dH);
          if (dHB && posBeg < 0) posBeg = int'(dH);
          if (dHE && posEnd < 0) posEnd = int'(dH);
          if (dHCE && posCE < 0) posCE = int'(dH);
        end
        if (t == 655) dVat655 = int'(dV);
        if (t == 656) dVat656 = int'(dV);
      end
      t++;
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    #1 nrst = 1'b1;
    countEn = 1'b1;
    repeat (NFRAMES * SFRAME) @(negedge clk);
    #1 countEn = 1'b0;

    // Hand-computed expectations pinning the model.
    chk("vga.hVisEnd.pos", 32'(posVis), 32'd639);
    chk("vga.hBegin.pos", 32'(posBeg), 32'd655);
    chk("vga.hEnd.pos", 32'(posEnd), 32'd751);
    chk("vga.hCountEnd.pos", 32'(posCE), 32'd799);
    chk("vga.vCount.at655", 32'(dVat655), 32'd0);
    chk("vga.vCount.at656", 32'(dVat656), 32'd1);
    chk("small.vCount.lastLineEnd", 32'(sVat191), 32'd0);
    chk("small.vBegin.count", 32'(nVB), 32'd257);
    chk("small.vBegin.line", 32'(lastVBv), 32'd8);
    chk("small.vEnd.count", 32'(nVE), 32'd257);
    chk("small.vEnd.line", 32'(lastVEv), 32'd10);
    chk("small.vVisEnd.atEnd", 32'(nVVE), 32'd257);
    chk("small.vCountEnd.atEnd", 32'(nVCE), 32'd257);
    chk("small.vEndActive.atEnd", 32'(nVEA), 32'd257);
`ifdef TIMING_FRAME_COUNT_EN
    chk("small.frameStart.count", 32'(nFS), 32'd257);
    chk("small.frameCount.wrap", 32'(sFC), 32'd1);
`else
    chk("small.frameStart.count", 32'(nFS), 32'd0);
    chk("small.frameCount.tied", 32'(sFC), 32'd0);
`endif

    // Asynchronous reset mid-frame, between clock edges.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #2;
      if (sH == 10'd6 && sV == 10'd5) found = 1'b1;
    end
    chk("small.midFramePoint.found", 32'(found), 32'd1);
    nrst = 1'b0;
    #1;
    chk("async.small.hCount", 32'(sH), 32'd0);
    chk("async.small.vCount", 32'(sV), 32'd0);
    chk("async.vga.hCount", 32'(dH), 32'd0);
    chk("async.vga.vCount", 32'(dV), 32'd0);
    chk("async.small.strobes", 32'({sHB, sHE, sHCE, sHVE, sVB, sVE, sVZ, sVVE, sVCE, sVEA, sFS}),
        32'b00000010000);
    chk("async.vga.strobes", 32'({dHB, dHE, dHCE, dHVE, dVB, dVE, dVZ, dVVE, dVCE, dVEA, dFS}),
        32'b00000010000);
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
    repeat (2 * SFRAME) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
